mem_access_stage: RTL

- Memory stage of the non-pipelined LEGv8 datapath; sits between execute and writeback.
- Accepts one memory operation from execute and drives a req/ack data-memory bus with variable wait states.
- Extracts, aligns and extends load data.
- Presents registered alu_result, read_data, pc, mem_to_reg and opcode to the writeback stage with a one-cycle out_valid pulse.

---
 rtl/mem_access_stage.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: LEGv8 memory stage between execute and writeback.
// Takes one operation at a time, runs it over a req/ack data bus with any
// number of wait states, aligns and extends load data, and hands registered
// results to writeback with a single-cycle out_valid pulse.
// Optional build macro: MEM_TIMEOUT_EN adds a bus wait-cycle watchdog that
// aborts a stuck transfer after TIMEOUT cycles and reports bus_error.
module mem_access_stage #(
    parameter int WORD    = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                busy,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [1:0]          size,
    input  logic                sign_ext,
    input  logic [WORD-1:0]     alu_result,
    input  logic [WORD-1:0]     store_data,
    input  logic [WORD-1:0]     pc_in,
    input  logic [1:0]          mem_to_reg_in,
    input  logic [10:0]         opcode_in,
    output logic                mem_req,
    output logic                mem_we,
    output logic [WORD-1:0]     mem_addr,
    output logic [WORD/8-1:0]   mem_be,
    output logic [WORD-1:0]     mem_wdata,
    input  logic                mem_ack,
    input  logic [WORD-1:0]     mem_rdata,
    output logic                out_valid,
    output logic [WORD-1:0]     alu_result_out,
    output logic [WORD-1:0]     read_data_out,
    output logic [WORD-1:0]     pc_out,
    output logic [1:0]          mem_to_reg_out,
    output logic [10:0]         opcode_out,
    output logic                misalign_fault,
    output logic                bus_error
);

    localparam int LANES = WORD / 8;
    localparam int OFFW  = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    // The watchdog counter is 8 bits wide; an out-of-range TIMEOUT leaves
    // this marker block in the elaborated hierarchy where it is easy to spot.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_out_of_range
    end

    state_t                 state_q, state_d;
    logic                   mem_req_q, mem_req_d;
    logic                   mem_we_q, mem_we_d;
    logic [WORD-1:0]        mem_addr_q, mem_addr_d;
    logic [LANES-1:0]       mem_be_q, mem_be_d;
    logic [WORD-1:0]        mem_wdata_q, mem_wdata_d;
    logic                   out_valid_q, out_valid_d;
    logic [WORD-1:0]        alu_q, alu_d;
    logic [WORD-1:0]        rdata_out_q, rdata_out_d;
    logic [WORD-1:0]        pc_q, pc_d;
    logic [1:0]             m2r_q, m2r_d;
    logic [10:0]            opc_q, opc_d;
    logic                   misalign_q, misalign_d;
    logic                   bus_err_q, bus_err_d;
    logic [1:0]             size_q, size_d;
    logic                   sign_q, sign_d;
    logic                   load_q, load_d;
`ifdef MEM_TIMEOUT_EN
    logic [7:0]             wait_cnt_q, wait_cnt_d;
`endif

    // Lane decode of the incoming operation (used only at capture time)
    logic [OFFW-1:0]        in_lo;
    logic [OFFW-1:0]        size_mask;
    logic                   in_misalign;
    logic [LANES-1:0]       in_be;
    logic [WORD-1:0]        in_wdata;

    // Load extraction from the bus word using the captured lane/size/sign
    logic [WORD-1:0]        ld_shift;
    logic [WORD-1:0]        ld_keep;
    logic                   ld_msb;
    logic [WORD-1:0]        ld_data;

    // Decode byte-lane offset, alignment, enables and shifted store data
    always_comb begin
        in_lo       = alu_result[OFFW-1:0];
        size_mask   = OFFW'((1 << size) - 1);
        in_misalign = (in_lo & size_mask) != '0;
        in_be       = LANES'(((1 << (1 << size)) - 1) << in_lo);
        in_wdata    = store_data << {in_lo, 3'b000};
    end

    // Right-align returned data, keep 2^size bytes, then sign/zero extend
    always_comb begin
        ld_shift = mem_rdata >> {alu_q[OFFW-1:0], 3'b000};
        ld_keep  = ~({WORD{1'b1}} << (8 << size_q));
        case (size_q)
            2'd0:    ld_msb = ld_shift[7];
            2'd1:    ld_msb = ld_shift[15];
            2'd2:    ld_msb = ld_shift[31];
            default: ld_msb = ld_shift[WORD-1];
        endcase
        ld_data = (ld_shift & ld_keep) | ((sign_q && ld_msb) ? ~ld_keep : '0);
    end

    // Next-state and next-output logic for the IDLE/REQ/DONE sequencer
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        out_valid_d = 1'b0;
        alu_d       = alu_q;
        rdata_out_d = rdata_out_q;
        pc_d        = pc_q;
        m2r_d       = m2r_q;
        opc_d       = opc_q;
        misalign_d  = misalign_q;
        bus_err_d   = bus_err_q;
        size_d      = size_q;
        sign_d      = sign_q;
        load_d      = load_q;
`ifdef MEM_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    alu_d       = alu_result;
                    pc_d        = pc_in;
                    m2r_d       = mem_to_reg_in;
                    opc_d       = opcode_in;
                    size_d      = size;
                    sign_d      = sign_ext;
                    load_d      = mem_read;
                    rdata_out_d = '0;
                    misalign_d  = 1'b0;
                    bus_err_d   = 1'b0;
                    if (!mem_read && !mem_write) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else if (in_misalign) begin
                        // Faulting access never reaches the bus
                        misalign_d  = 1'b1;
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = mem_write;
                        mem_addr_d  = {alu_result[WORD-1:OFFW], {OFFW{1'b0}}};
                        mem_be_d    = in_be;
                        mem_wdata_d = in_wdata;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt_d  = '0;
`endif
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_be_d    = '0;
                    mem_wdata_d = '0;
                    if (load_q) rdata_out_d = ld_data;
                end
`ifdef MEM_TIMEOUT_EN
                else if (int'(wait_cnt_q) + 1 >= TIMEOUT) begin
                    // Give up on the slave; any later ack lands outside REQ
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    bus_err_d   = 1'b1;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_be_d    = '0;
                    mem_wdata_d = '0;
                end else begin
                    wait_cnt_d  = wait_cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset kills any in-flight request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            out_valid_q <= 1'b0;
            alu_q       <= '0;
            rdata_out_q <= '0;
            pc_q        <= '0;
            m2r_q       <= '0;
            opc_q       <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            size_q      <= '0;
            sign_q      <= 1'b0;
            load_q      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            out_valid_q <= out_valid_d;
            alu_q       <= alu_d;
            rdata_out_q <= rdata_out_d;
            pc_q        <= pc_d;
            m2r_q       <= m2r_d;
            opc_q       <= opc_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            load_q      <= load_d;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign busy           = (state_q != IDLE);
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_be         = mem_be_q;
    assign mem_wdata      = mem_wdata_q;
    assign out_valid      = out_valid_q;
    assign alu_result_out = alu_q;
    assign read_data_out  = rdata_out_q;
    assign pc_out         = pc_q;
    assign mem_to_reg_out = m2r_q;
    assign opcode_out     = opc_q;
    assign misalign_fault = misalign_q;
    assign bus_error      = bus_err_q;

endmodule
